// File: rtl/piso_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | piso_serializer: valid/ready parallel-in, serial-out word serializer   |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_VALID,
  output logic             READY,
  output logic             O,
  output logic             O_VALID,
  output logic             O_LAST
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;
  logic             w_at_last;
  logic             w_accept;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign w_out_bit = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign w_out_bit = shreg_q[0];
    end
  endgenerate

  assign w_at_last = (state_q == ST_SHIFT) && (cnt_q == C_LAST);
  assign w_accept  = I_VALID && READY;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // READY already folds in CE, so an accept can only happen on an enabled edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            shreg_d = I_DATA;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q != C_LAST) begin
            shreg_d = w_shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (w_accept) begin
            shreg_d = I_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    READY   = CE && !ASYNCRESET && ((state_q == ST_IDLE) || w_at_last);
    O       = (state_q == ST_SHIFT) ? w_out_bit : IDLE_LEVEL;
    O_VALID = (state_q == ST_SHIFT);
    O_LAST  = w_at_last;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out serializer that feeds the 8-stage serial delay line (SISO8) directly upstream. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on O, with framing strobes. Back-to-back words stream without a gap cycle. A clock enable freezes all state, so the serializer can stall in lockstep with downstream clock-enabled stages.

Parameters:
WIDTH, 8, word width in bits; must be at least 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_LEVEL, 0, value driven on O when no word is being shifted.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
ASYNCRESET  input  1  asynchronous, active-high reset.
CE  input  1  clock enable; when low, all state holds.
I_DATA  input  WIDTH  parallel word to serialize.
I_VALID  input  1  I_DATA is valid.
READY  output  1  serializer can accept a word this cycle.
O  output  1  serial data bit, connected to SISO8 I.
O_VALID  output  1  O carries a data bit this cycle.
O_LAST  output  1  O carries the final bit of the current word.

Behaviour:
- State: FSM {IDLE, SHIFT}, WIDTH-bit shift register `shreg`, bit counter `cnt` (clog2(WIDTH) bits).
- Reset (async, immediate):
  - state=IDLE, cnt=0, shreg=0.
  - Outputs: O=IDLE_LEVEL, O_VALID=0, O_LAST=0.
  - READY is forced 0 while ASYNCRESET is high. It is 1 from the first cycle after deassertion, provided CE=1.
- READY = CE & !ASYNCRESET & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)).
- accept = I_VALID & READY. Data is sampled only on accept. I_DATA is don't-care otherwise.
- IDLE, rising edge:
  - If accept: shreg<=I_DATA, cnt<=0, state<=SHIFT.
  - Otherwise hold.
- SHIFT, rising edge with CE=1 and cnt<WIDTH-1:
  - Shift shreg by one position toward the output end (left if MSB_FIRST, else right); the vacated bit fills with 0.
  - cnt<=cnt+1.
- SHIFT, rising edge with CE=1 and cnt==WIDTH-1:
  - If accept: reload shreg<=I_DATA, cnt<=0, stay in SHIFT. This gives gapless streaming.
  - Otherwise state<=IDLE, cnt<=0.
- Outputs are combinational from registered state only; there is no input-to-output combinational path except READY←CE/ASYNCRESET.
  - O = state==SHIFT ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL.
  - O_VALID = (state==SHIFT).
  - O_LAST = (state==SHIFT) & (cnt==WIDTH-1).
- Latency: first bit appears on O in the cycle after the accept edge. A word occupies exactly WIDTH O_VALID cycles when CE=1.
- CE=0: shreg, cnt and state hold, so O, O_VALID and O_LAST hold their values. READY=0, so no accept can occur.
- I_VALID held high with READY=0 has no effect. The upstream source must hold I_DATA until accept.
- Reset mid-word: the word is discarded immediately. O returns to IDLE_LEVEL with no partial-word completion.
- cnt never exceeds WIDTH-1. The wrap from WIDTH-1 to 0 occurs only on the last-bit edge.

Test Plan:
1. Reset, then single word 0xA5 (MSB_FIRST=1, CE=1):
   - O must be 1,0,1,0,0,1,0,1 over cycles 1–8 after accept, with O_VALID=1 throughout.
   - O_LAST=1 on cycle 8 only.
   - Cycle 9: O=0, O_VALID=0, READY=1.
2. Back-to-back 0xA5 then 0x3C, I_VALID held high:
   - The second accept occurs on the O_LAST cycle.
   - O shows 16 contiguous valid bits: 10100101 00111100, with no gap.
   - O_LAST pulses on cycles 8 and 16.
3. CE stall:
   - Send 0xF0 and drop CE for 3 cycles after bit 2 is presented.
   - O must hold 1 and O_VALID hold 1 during the stall, with READY=0.
   - The sequence then resumes 1,1,0,0,0,0, for 8 valid bits total.
4. Reset mid-word:
   - Assert ASYNCRESET between edges during bit 4 of 0xFF.
   - O drops to IDLE_LEVEL, O_VALID=0 and READY=0 immediately, without waiting for a clock edge.
   - After release, 0x81 serializes cleanly as 1,0,0,0,0,0,0,1.
5. MSB_FIRST=0, IDLE_LEVEL=1, word 0x01:
   - O is 1 while idle.
   - O then shows 1,0,0,0,0,0,0,0, and returns to 1 when idle.
6. Chained with SISO8:
   - Serialize 0xC3.
   - SISO8 O reproduces 1,1,0,0,0,0,1,1, exactly 8 cycles later than the serializer's O.
